// File: rtl/lcd_scan_driver.sv
// Multi-digit, time-multiplexed 7-segment driver with blink and alarm sequencing.
// Scans NUM_DIGITS BCD digits onto a shared segment bus, blinks during time entry,
// and rings an alarm when the running time matches the stored alarm time.
module lcd_scan_driver #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned BLINK_FRAMES = 64,
    parameter int unsigned ALARM_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] key_time,
    input  logic [4*NUM_DIGITS-1:0] alarm_time,
    input  logic [4*NUM_DIGITS-1:0] current_time,
    input  logic                    show_new_time,
    input  logic                    show_alarm,
    input  logic                    alarm_enable,
    input  logic                    alarm_stop,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    sound_alarm
);

    localparam int unsigned IdxW  = $clog2(NUM_DIGITS);
    localparam int unsigned PreW  = $clog2(SCAN_DIV);
    // A single-frame blink period still needs a one-bit counter.
    localparam int unsigned BlkW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned RingW = $clog2(ALARM_CYCLES);

    typedef enum logic [1:0] {StIdle, StRinging, StAcked} state_e;

    state_e                  state_q, state_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [PreW-1:0]         pre_q, pre_d;
    logic [BlkW-1:0]         blink_q, blink_d;
    logic                    blank_q, blank_d;
    logic [RingW-1:0]        ring_q, ring_d;
    logic                    match_q;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;

    logic [4*NUM_DIGITS-1:0] src;
    logic [3:0]              nib;
    logic                    tick, frame_end, match, rise, all_bcd;

    function automatic logic [6:0] decode(input logic [3:0] b);
        case (b)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    // Source select, current nibble, alarm match detection.
    always_comb begin
        if (show_new_time)   src = key_time;
        else if (show_alarm) src = alarm_time;
        else                 src = current_time;
        nib     = '0;
        all_bcd = 1'b1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx_q == IdxW'(i)) nib = src[4*i +: 4];
            if (current_time[4*i +: 4] > 4'd9) all_bcd = 1'b0;
        end
        tick      = (pre_q == PreW'(SCAN_DIV - 1));
        frame_end = tick && (idx_q == IdxW'(NUM_DIGITS - 1));
        match     = alarm_enable && (current_time == alarm_time) && all_bcd;
        rise      = match && !match_q;
    end

    // Prescaler, digit scan and segment/digit-enable next state.
    always_comb begin
        pre_d = tick ? '0 : pre_q + PreW'(1);
        idx_d = idx_q;
        seg_d = seg_q;
        sel_d = sel_q;
        if (tick) begin
            idx_d = (idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
            for (int i = 0; i < int'(NUM_DIGITS); i++) sel_d[i] = (idx_q == IdxW'(i));
            seg_d = blank_q ? 8'h00 : {alarm_enable && (idx_q == '0), decode(nib)};
        end
    end

    // Blink counter: counts whole frames only while a new time is being entered.
    always_comb begin
        blink_d = blink_q;
        blank_d = blank_q;
        if (!show_new_time) begin
            blink_d = '0;
            blank_d = 1'b0;
        end else if (frame_end) begin
            if (blink_q == BlkW'(BLINK_FRAMES - 1)) begin
                blink_d = '0;
                blank_d = !blank_q;
            end else begin
                blink_d = blink_q + BlkW'(1);
            end
        end
    end

    // Alarm FSM next state and ring counter.
    always_comb begin
        state_d = state_q;
        ring_d  = ring_q;
        unique case (state_q)
            StIdle: begin
                if (rise && alarm_stop) begin
                    state_d = StAcked;
                end else if (rise) begin
                    state_d = StRinging;
                    ring_d  = '0;
                end
            end
            StRinging: begin
                if (alarm_stop || !alarm_enable || ring_q == RingW'(ALARM_CYCLES - 1)) begin
                    state_d = StAcked;
                end else begin
                    ring_d = ring_q + RingW'(1);
                end
            end
            StAcked: begin
                if (!match) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            pre_q   <= '0;
            blink_q <= '0;
            blank_q <= 1'b0;
            ring_q  <= '0;
            match_q <= 1'b0;
            seg_q   <= 8'h00;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pre_q   <= pre_d;
            blink_q <= blink_d;
            blank_q <= blank_d;
            ring_q  <= ring_d;
            match_q <= match;
            seg_q   <= seg_d;
            sel_q   <= sel_d;
        end
    end

    assign seg         = seg_q;
    assign digit_sel   = sel_q;
    assign sound_alarm = (state_q == StRinging);

endmodule
